// File: rtl/fetch_sequencer_if.sv
// Instruction-bus, downstream-slot and redirect signals of the fetch sequencer.
// master is the sequencer's view, slave is the bus/slice/CP0 side.
interface fetch_sequencer_if;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        iresp_addr_ok;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_delay_slot;
    logic        out_addr_invalid;
    logic        out_interrupt;
    logic        int_pending;
    logic        br_valid;
    logic [31:0] br_target;
    logic        flush_valid;
    logic [31:0] flush_pc;

    modport master (
        output ireq_valid, ireq_addr, out_valid, out_pc, out_instr,
               out_delay_slot, out_addr_invalid, out_interrupt,
        input  iresp_addr_ok, iresp_data_ok, iresp_data, out_ready,
               int_pending, br_valid, br_target, flush_valid, flush_pc
    );

    modport slave (
        input  ireq_valid, ireq_addr, out_valid, out_pc, out_instr,
               out_delay_slot, out_addr_invalid, out_interrupt,
        output iresp_addr_ok, iresp_data_ok, iresp_data, out_ready,
               int_pending, br_valid, br_target, flush_valid, flush_pc
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the PC, issues one bus request at a time, holds the
// fetched slot until downstream takes it, and applies branch and flush redirects.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input logic               clk,
    input logic               resetn,
    fetch_sequencer_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;

    state_t      r_state, w_next;
    logic [31:0] r_pc, r_br_tgt, r_out_pc, r_out_instr;
    logic        r_delay, r_br_pend, r_out_ai;
    logic        w_aligned, w_flush, w_br_take;
    logic        w_hs, w_load_bus, w_load_bad, w_ireq_valid, w_out_valid;

    assign w_aligned = (r_pc[1:0] == 2'b00);
    assign w_flush   = bus.flush_valid && (r_state != S_IDLE);
    // A branch reported for the delay slot itself is not a new branch.
    assign w_br_take = bus.br_valid && !r_br_pend;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_hs         = 1'b0;
        w_load_bus   = 1'b0;
        w_load_bad   = 1'b0;
        w_ireq_valid = 1'b0;
        w_out_valid  = 1'b0;
        case (r_state)
            S_IDLE: w_next = S_REQ;
            S_REQ: begin
                w_ireq_valid = w_aligned;
                if (w_flush) begin
                    // An address already accepted must have its response drained.
                    w_next = (w_aligned && bus.iresp_addr_ok) ? S_DRAIN : S_REQ;
                end else if (!w_aligned) begin
                    w_load_bad = 1'b1;
                    w_next     = S_HOLD;
                end else if (bus.iresp_addr_ok) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_flush) begin
                    w_next = bus.iresp_data_ok ? S_REQ : S_DRAIN;
                end else if (bus.iresp_data_ok) begin
                    w_load_bus = 1'b1;
                    w_next     = S_HOLD;
                end
            end
            S_HOLD: begin
                w_out_valid = 1'b1;
                if (w_flush) begin
                    w_next = S_REQ;
                end else if (bus.out_ready) begin
                    w_hs   = 1'b1;
                    w_next = S_REQ;
                end
            end
            S_DRAIN: begin
                if (bus.iresp_data_ok) w_next = S_REQ;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pc        <= RESET_PC;
            r_delay     <= 1'b0;
            r_br_pend   <= 1'b0;
            r_br_tgt    <= '0;
            r_out_pc    <= '0;
            r_out_instr <= '0;
            r_out_ai    <= 1'b0;
        end else begin
            if (w_flush) begin
                r_pc      <= bus.flush_pc;
                r_delay   <= 1'b0;
                r_br_pend <= 1'b0;
            end else if (w_hs) begin
                // The redirect lands only after the delay slot has been handed over.
                r_pc      <= r_br_pend ? r_br_tgt : r_pc + PC_STEP;
                r_delay   <= w_br_take;
                r_br_pend <= w_br_take;
                if (w_br_take) r_br_tgt <= bus.br_target;
            end
            if (w_load_bus) begin
                r_out_pc    <= r_pc;
                r_out_instr <= bus.iresp_data;
                r_out_ai    <= 1'b0;
            end else if (w_load_bad) begin
                r_out_pc    <= r_pc;
                r_out_instr <= '0;
                r_out_ai    <= 1'b1;
            end
        end
    end

    assign bus.ireq_valid       = w_ireq_valid;
    assign bus.ireq_addr        = r_pc;
    assign bus.out_valid        = w_out_valid;
    assign bus.out_pc           = r_out_pc;
    assign bus.out_instr        = r_out_instr;
    assign bus.out_delay_slot   = r_delay;
    assign bus.out_addr_invalid = r_out_ai;
    assign bus.out_interrupt    = bus.int_pending & w_out_valid;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios with literal expectations, then random
// traffic checked every cycle against a slot-level reference model.
module tb_fetch_sequencer;
    localparam logic [31:0] RST_PC = 32'hbfc0_0000;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    fetch_sequencer_if bus ();
    fetch_sequencer #(.RESET_PC(RST_PC), .PC_STEP(32'd4)) dut (
        .clk(clk), .resetn(resetn), .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    // ---------------- stimulus and bus responder ----------------
    bit          rnd = 1'b0;
    int          aok_pct = 100;
    int          dly = 1;
    logic        d_ready = 1'b0, d_br = 1'b0, d_flush = 1'b0, d_int = 1'b0;
    logic [31:0] d_tgt = '0, d_fpc = '0;
    bit          outst = 1'b0;
    int          cnt = 0;
    logic [31:0] acc = '0;
    bit          ovr_valid = 1'b0;
    logic [31:0] ovr_data = '0;
    bit          force_dok = 1'b0;
    logic [31:0] req_log[$];
    int          ireq_cycles = 0;
    int          stim_age = 0;

    task automatic step();
        logic aok, dok;
        logic [31:0] a;
        if (rnd) begin
            d_ready = ($urandom_range(99) < 70);
            d_br    = ($urandom_range(99) < 30);
            d_tgt   = RST_PC | ($urandom & 32'h0000_fffc);
            d_int   = 1'($urandom_range(1));
            d_flush = (stim_age > 1) && ($urandom_range(99) < 3);
            d_fpc   = RST_PC | ($urandom & 32'h0000_fffc);
            if ($urandom_range(7) == 0) d_fpc[1:0] = 2'($urandom_range(3, 1));
            dly     = int'($urandom_range(3, 1));
            aok_pct = 60;
        end
        aok = resetn && bus.ireq_valid && !outst && ($urandom_range(99) < aok_pct);
        dok = (outst && cnt == 0) || force_dok;
        a   = bus.ireq_addr;
        if (bus.ireq_valid) ireq_cycles++;
        bus.iresp_addr_ok = aok;
        bus.iresp_data_ok = dok;
        if (!dok)           bus.iresp_data = $urandom;
        else if (force_dok) bus.iresp_data = 32'h1234_5678;
        else if (ovr_valid) bus.iresp_data = ovr_data;
        else                bus.iresp_data = mem(acc);
        bus.out_ready   = d_ready;
        bus.br_valid    = d_br;
        bus.br_target   = d_tgt;
        bus.flush_valid = d_flush;
        bus.flush_pc    = d_fpc;
        bus.int_pending = d_int;
        @(posedge clk);
        #1;
        if (dok && outst) begin
            outst = 1'b0;
            ovr_valid = 1'b0;
        end else if (outst) begin
            cnt--;
        end
        force_dok = 1'b0;
        if (aok) begin
            outst = 1'b1;
            acc = a;
            cnt = dly - 1;
            req_log.push_back(a);
        end
        if (!resetn) outst = 1'b0;
        stim_age = resetn ? stim_age + 1 : 0;
    endtask

    // Hand over the next slot (optionally reporting a taken branch) and return its fields.
    task automatic take(input logic br, input logic [31:0] tgt, output logic [31:0] pc,
                        output logic [31:0] ins, output logic ds, output logic ai);
        bit got = 1'b0;
        int n = 0;
        pc = '0; ins = '0; ds = 1'b0; ai = 1'b0;
        d_ready = 1'b1;
        while (!got && n < 60) begin
            if (bus.out_valid) begin
                pc = bus.out_pc; ins = bus.out_instr;
                ds = bus.out_delay_slot; ai = bus.out_addr_invalid;
                got = 1'b1;
            end
            d_br = got ? br : 1'b0;
            d_tgt = tgt;
            step();
            n++;
        end
        d_br = 1'b0;
        if (!got) chk("take_timeout", 32'(got), 32'd1);
    endtask

    task automatic wait_hold();
        int n = 0;
        d_ready = 1'b0;
        while (!bus.out_valid && n < 60) begin
            step();
            n++;
        end
        if (!bus.out_valid) chk("hold_timeout", 32'(bus.out_valid), 32'd1);
    endtask

    task automatic wait_req();
        int n = 0;
        d_ready = 1'b1;
        while (!bus.ireq_valid && n < 60) begin
            step();
            n++;
        end
        if (!bus.ireq_valid) chk("req_timeout", 32'(bus.ireq_valid), 32'd1);
    endtask

    task automatic flush_to(input logic [31:0] fpc, input logic rdy);
        d_flush = 1'b1; d_fpc = fpc; d_ready = rdy;
        step();
        d_flush = 1'b0; d_ready = 1'b0;
    endtask

    // ---------------- reference model and per-cycle compare ----------------
    logic [31:0] m_pc = RST_PC, m_tgt = '0;
    logic        m_delay = 1'b0, m_pend = 1'b0;
    bit          m_outst = 1'b0, m_live = 1'b0, p_dok_live = 1'b0;
    bit          p_ov = 1'b0, p_hs = 1'b0, p_fl = 1'b0;
    int          m_age = 0, idle_run = 0;

    always @(negedge clk) begin
        bit fl, hs, b;
        if (!resetn) begin
            m_pc = RST_PC; m_tgt = '0; m_delay = 1'b0; m_pend = 1'b0;
            m_outst = 1'b0; m_live = 1'b0; p_dok_live = 1'b0;
            p_ov = 1'b0; p_hs = 1'b0; p_fl = 1'b0; m_age = 0; idle_run = 0;
            chk("rst_ireq_valid", 32'(bus.ireq_valid), 32'd0);
            chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        end else begin
            if (m_age == 0) begin
                chk("idle_ireq_valid", 32'(bus.ireq_valid), 32'd0);
                chk("idle_out_valid", 32'(bus.out_valid), 32'd0);
            end
            if (bus.ireq_valid) begin
                chk("ireq_addr", bus.ireq_addr, m_pc);
                chk("ireq_aligned", 32'(m_pc[1:0]), 32'd0);
                chk("ireq_while_busy", 32'(m_outst || bus.out_valid), 32'd0);
            end
            if (bus.out_valid) begin
                chk("out_pc", bus.out_pc, m_pc);
                chk("out_instr", bus.out_instr, (m_pc[1:0] == 2'b00) ? mem(m_pc) : 32'd0);
                chk("out_addr_invalid", 32'(bus.out_addr_invalid), 32'(m_pc[1:0] != 2'b00));
                chk("out_delay_slot", 32'(bus.out_delay_slot), 32'(m_delay));
            end
            chk("out_interrupt", 32'(bus.out_interrupt), 32'(bus.int_pending && bus.out_valid));
            if (m_age > 0 && m_pc[1:0] == 2'b00 && ((bus.out_valid && !p_ov) || p_dok_live))
                chk("slot_after_data", 32'(bus.out_valid && !p_ov), 32'(p_dok_live));
            if (p_hs || p_fl) chk("slot_dropped", 32'(bus.out_valid), 32'd0);
            if (!bus.ireq_valid && !bus.out_valid && !m_outst) idle_run++;
            else idle_run = 0;
            if (idle_run >= 12) begin
                chk("progress", 32'(idle_run), 32'd0);
                idle_run = 0;
            end

            fl = bus.flush_valid && (m_age > 0);
            hs = bus.out_valid && bus.out_ready;
            if (bus.ireq_valid && bus.iresp_addr_ok) begin
                m_outst = 1'b1;
                m_live = !fl;
            end
            p_dok_live = 1'b0;
            if (bus.iresp_data_ok && m_outst) begin
                p_dok_live = m_live && !fl;
                m_outst = 1'b0;
                m_live = 1'b0;
            end
            if (fl) m_live = 1'b0;
            if (fl) begin
                m_pc = bus.flush_pc; m_delay = 1'b0; m_pend = 1'b0;
            end else if (hs) begin
                b = bus.br_valid && !m_pend;
                m_pc = m_pend ? m_tgt : m_pc + 32'd4;
                m_delay = b;
                m_pend = b;
                if (b) m_tgt = bus.br_target;
            end
            p_hs = hs && !fl;
            p_fl = fl;
            p_ov = bus.out_valid;
            m_age++;
        end
    end

    // ---------------- directed scenarios, then random traffic ----------------
    initial begin
        logic [31:0] pc, ins;
        logic ds, ai;
        int c;
        bus.iresp_addr_ok = 1'b0; bus.iresp_data_ok = 1'b0; bus.iresp_data = '0;
        bus.out_ready = 1'b0; bus.int_pending = 1'b0; bus.br_valid = 1'b0;
        bus.br_target = '0; bus.flush_valid = 1'b0; bus.flush_pc = '0;
        repeat (3) step();
        chk("rst_out_pc", bus.out_pc, 32'd0);
        chk("rst_out_instr", bus.out_instr, 32'd0);
        chk("rst_ireq_addr", bus.ireq_addr, RST_PC);
        resetn = 1'b1;

        // sequential fetch from reset
        req_log.delete();
        take(1'b0, '0, pc, ins, ds, ai); chk("seq_pc0", pc, 32'hbfc0_0000);
        take(1'b0, '0, pc, ins, ds, ai); chk("seq_pc1", pc, 32'hbfc0_0004);
        take(1'b0, '0, pc, ins, ds, ai); chk("seq_pc2", pc, 32'hbfc0_0008);
        chk("seq_instr2", ins, mem(32'hbfc0_0008));
        for (int i = 0; i < 3; i++)
            chk("seq_req_addr", (i < req_log.size()) ? req_log[i] : 32'hffff_ffff,
                32'hbfc0_0000 + 32'(4 * i));

        // branch with delay slot
        take(1'b0, '0, pc, ins, ds, ai);
        take(1'b1, 32'hbfc0_0100, pc, ins, ds, ai); chk("br_pc", pc, 32'hbfc0_0010);
        take(1'b0, '0, pc, ins, ds, ai); chk("dslot_pc", pc, 32'hbfc0_0014);
        chk("dslot_flag", 32'(ds), 32'd1);
        take(1'b0, '0, pc, ins, ds, ai); chk("target_pc", pc, 32'hbfc0_0100);
        chk("target_flag", 32'(ds), 32'd0);

        // downstream stall
        wait_hold();
        c = ireq_cycles;
        repeat (5) begin
            chk("stall_pc", bus.out_pc, 32'hbfc0_0104);
            chk("stall_instr", bus.out_instr, mem(32'hbfc0_0104));
            step();
        end
        chk("stall_no_req", 32'(ireq_cycles), 32'(c));
        take(1'b0, '0, pc, ins, ds, ai); chk("stall_release_pc", pc, 32'hbfc0_0104);
        take(1'b0, '0, pc, ins, ds, ai); chk("stall_next_pc", pc, 32'hbfc0_0108);

        // back-to-back branches: the second one, in the delay slot, is ignored
        take(1'b1, 32'hbfc0_0600, pc, ins, ds, ai);
        take(1'b1, 32'hbfc0_0700, pc, ins, ds, ai); chk("b2b_dslot", 32'(ds), 32'd1);
        take(1'b0, '0, pc, ins, ds, ai); chk("b2b_target", pc, 32'hbfc0_0600);
        take(1'b0, '0, pc, ins, ds, ai); chk("b2b_after", pc, 32'hbfc0_0604);

        // flush while waiting for data: the late word must never appear
        wait_req();
        dly = 3; ovr_valid = 1'b1; ovr_data = 32'hdead_beef;
        step();
        flush_to(32'hbfc0_0380, 1'b1);
        dly = 1;
        req_log.delete();
        take(1'b0, '0, pc, ins, ds, ai); chk("wflush_pc", pc, 32'hbfc0_0380);
        chk("wflush_instr", ins, mem(32'hbfc0_0380));
        chk("wflush_req", (req_log.size() > 0) ? req_log[0] : 32'hffff_ffff, 32'hbfc0_0380);

        // misaligned redirect: AdEL slot without a bus access
        wait_hold();
        flush_to(32'hbfc0_0381, 1'b0);
        c = ireq_cycles;
        take(1'b0, '0, pc, ins, ds, ai); chk("adel_pc", pc, 32'hbfc0_0381);
        chk("adel_flag", 32'(ai), 32'd1);
        chk("adel_instr", ins, 32'd0);
        chk("adel_no_req", 32'(ireq_cycles), 32'(c));

        // interrupt qualification and flush racing a handshake
        wait_hold();
        d_int = 1'b1; bus.int_pending = 1'b1;
        #1;
        chk("int_held", 32'(bus.out_interrupt), 32'd1);
        flush_to(32'hbfc0_0500, 1'b1);
        chk("int_no_slot", 32'(bus.out_interrupt), 32'd0);
        take(1'b0, '0, pc, ins, ds, ai); chk("hflush_pc", pc, 32'hbfc0_0500);
        d_int = 1'b0;

        // PC wraps modulo 2^32
        wait_hold();
        flush_to(32'hffff_fffc, 1'b0);
        take(1'b0, '0, pc, ins, ds, ai); chk("wrap_pc0", pc, 32'hffff_fffc);
        take(1'b0, '0, pc, ins, ds, ai); chk("wrap_pc1", pc, 32'h0000_0000);

        // reset mid-transaction with a stray response in the first cycle after release
        wait_req();
        dly = 3;
        step();
        resetn = 1'b0;
        #1;
        chk("areset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("areset_ireq_addr", bus.ireq_addr, RST_PC);
        repeat (2) step();
        dly = 1;
        resetn = 1'b1;
        force_dok = 1'b1;
        step();
        take(1'b0, '0, pc, ins, ds, ai); chk("areset_pc", pc, RST_PC);
        chk("areset_instr", ins, mem(RST_PC));

        // random traffic
        rnd = 1'b1;
        repeat (3000) step();
        rnd = 1'b0;
        d_ready = 1'b0; d_br = 1'b0; d_flush = 1'b0; d_int = 1'b0; aok_pct = 100; dly = 1;
        repeat (10) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "timeout");
    end
endmodule
